md_unit: RTL and testbench

// - Parametrised multi-cycle multiply/divide unit with HI/LO registers for the pipelined datapath (E stage).
// - Successor to the single-cycle ALU path: adds signed/unsigned mult/div, configurable latency and MTHI/MTLO.
// - Adds a busy/stall handshake that the pipeline control ORs into its hazard stall.
// - Control freezes F/D and bubbles E while md_stall is high and D holds an MD-class instruction.

---
 rtl/md_unit.sv | 153 +++++++++++++++
 tb/tb_md_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// ============================================================================
// Module      : md_unit
// Description : Multi-cycle multiply/divide unit with HI/LO registers and a
//               busy/stall handshake for the E stage of the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             md_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;

    localparam int c_MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W = (c_MAX_N > 1) ? $clog2(c_MAX_N) : 1;
    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES - 1);
    localparam logic [WIDTH-1:0]   c_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_pend_hi;
    logic [WIDTH-1:0]     r_pend_lo;

    logic [2*WIDTH-1:0]   w_prod_s;
    logic [2*WIDTH-1:0]   w_prod_u;
    logic                 w_signed_div;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH-1:0]     w_divisor;
    logic [WIDTH-1:0]     w_uq;
    logic [WIDTH-1:0]     w_ur;
    logic [WIDTH-1:0]     w_q;
    logic [WIDTH-1:0]     w_r;
    logic                 w_div_zero;

    // Sign-extended operands give the signed product in the low 2*WIDTH bits.
    assign w_prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign w_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Signed divide through magnitudes; the most negative value maps to an
    // unsigned magnitude of 2^(WIDTH-1), so the overflow case wraps naturally.
    assign w_signed_div = (op == c_OP_DIV);
    assign w_a_neg      = w_signed_div & a[WIDTH-1];
    assign w_b_neg      = w_signed_div & b[WIDTH-1];
    assign w_a_mag      = w_a_neg ? -a : a;
    assign w_b_mag      = w_b_neg ? -b : b;
    assign w_div_zero   = (b == '0);
    assign w_divisor    = w_div_zero ? c_ONE : w_b_mag;
    assign w_uq         = w_a_mag / w_divisor;
    assign w_ur         = w_a_mag % w_divisor;
    assign w_q          = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
    assign w_r          = w_a_neg ? -w_ur : w_ur;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_IDLE) begin
            if (start && !op[2]) begin
                w_state_nxt = S_RUN;
            end
        end else begin
            if (r_cnt == '0) begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                case (op)
                    c_OP_MULT: begin
                        r_pend_hi <= w_prod_s[2*WIDTH-1:WIDTH];
                        r_pend_lo <= w_prod_s[WIDTH-1:0];
                        r_cnt     <= c_MULT_LOAD;
                    end
                    c_OP_MULTU: begin
                        r_pend_hi <= w_prod_u[2*WIDTH-1:WIDTH];
                        r_pend_lo <= w_prod_u[WIDTH-1:0];
                        r_cnt     <= c_MULT_LOAD;
                    end
                    c_OP_DIV, c_OP_DIVU: begin
                        // Divide by zero re-commits the current HI/LO.
                        r_pend_hi <= w_div_zero ? r_hi : w_r;
                        r_pend_lo <= w_div_zero ? r_lo : w_q;
                        r_cnt     <= c_DIV_LOAD;
                    end
                    c_OP_MTHI: r_hi <= a;
                    c_OP_MTLO: r_lo <= a;
                    default: ;
                endcase
            end
        end else begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign md_stall = start | busy;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module      : tb_md_unit
// Description : Directed and randomized checks of md_unit against a
//               cycle-level reference model built from 64-bit arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    int          m_left = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [31:0] m_phi  = '0;
    logic [31:0] m_plo  = '0;

    always #5 clk = ~clk;

    md_unit #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: an accepted op schedules its result to land N edges later.
    task automatic model_edge(input logic r, input logic s, input logic [2:0] o,
                              input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      rm;
        logic [63:0] p;
        if (r) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            case (o)
                3'd0: begin p = sx * sy; m_phi = p[63:32]; m_plo = p[31:0]; m_left = 5; end
                3'd1: begin p = {32'b0, x} * {32'b0, y}; m_phi = p[63:32]; m_plo = p[31:0]; m_left = 5; end
                3'd2: begin
                    m_left = 10;
                    if (y == 0) begin
                        m_phi = m_hi; m_plo = m_lo;
                    end else begin
                        q = sx / sy; rm = sx % sy;
                        m_phi = rm[31:0]; m_plo = q[31:0];
                    end
                end
                3'd3: begin
                    m_left = 10;
                    if (y == 0) begin
                        m_phi = m_hi; m_plo = m_lo;
                    end else begin
                        m_phi = x % y; m_plo = x / y;
                    end
                end
                3'd4: m_hi = x;
                3'd5: m_lo = x;
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        rst = r; start = s; op = o; a = x; b = y;
        #1;
        check("md_stall", md_stall, s | (m_left > 0));
        @(posedge clk);
        model_edge(r, s, o, x, y);
        #1;
        check("busy", busy, m_left > 0);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;

        // Reset with start pending, then reset one cycle into a MULT.
        step(1'b1, 1'b1, 3'd0, 32'd5, 32'd7);
        check("rst_busy", busy, 1'b0);
        check("rst_hi", hi, 32'd0);
        step(1'b0, 1'b1, 3'd0, 32'd5, 32'd7);
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        idle(8);
        check("abort_lo", lo, 32'd0);

        step(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFE, 32'h3);
        idle(5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        check("mult_done", busy, 1'b0);

        step(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFE, 32'h3);
        idle(5);
        check("multu_hi", hi, 32'h2);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        step(1'b0, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'h2);
        idle(10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        step(1'b0, 1'b1, 3'd3, 32'd7, 32'd2);
        idle(10);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        step(1'b0, 1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(10);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        step(1'b0, 1'b1, 3'd2, 32'd123, 32'd0);
        idle(10);
        check("div0_lo", lo, 32'h8000_0000);
        check("div0_hi", hi, 32'd0);

        // DIVU request while a MULT is in flight must be dropped.
        step(1'b0, 1'b1, 3'd0, 32'd6, 32'd7);
        step(1'b0, 1'b1, 3'd3, 32'd100, 32'd3);
        step(1'b0, 1'b1, 3'd3, 32'd100, 32'd3);
        idle(3);
        check("ign_lo", lo, 32'd42);
        check("ign_busy", busy, 1'b0);

        step(1'b0, 1'b1, 3'd4, 32'h1234, 32'd0);
        check("mthi_busy", busy, 1'b0);
        step(1'b0, 1'b1, 3'd5, 32'h5678, 32'd0);
        check("mt_hi", hi, 32'h1234);
        check("mt_lo", lo, 32'h5678);
        idle(1);

        step(1'b0, 1'b1, 3'd6, 32'hDEAD, 32'd1);
        check("rsvd_busy", busy, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
                 3'($urandom_range(0, 7)), pick(), pick());
        end
        idle(12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
